// File: rtl/m68k_bridge_pkg.sv
// Shared definitions for the 68000 bus-to-UART bridge: state encoding,
// request-packet layout and the packet byte builder.
package m68k_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_RX_STAT,
        S_RX_DATA,
        S_TERM
    } state_e;

    // Header byte: {1, rw, uds, lds, 0, fc[2:0]}
    localparam int HDR_MARK_BIT = 7;
    localparam int HDR_RW_BIT   = 6;
    localparam int HDR_UDS_BIT  = 5;
    localparam int HDR_LDS_BIT  = 4;
    localparam int HDR_FC_LSB   = 0;

    localparam logic [7:0] ACK_BYTE_DEFAULT = 8'h06;

    localparam int PKT_LEN_RD = 4;
    localparam int PKT_LEN_WR = 6;

    typedef struct packed {
        logic        rw;
        logic        uds;
        logic        lds;
        logic [2:0]  fc;
        logic [22:0] addr_hi;   // addr[23:1]
        logic [15:0] data;
    } bus_req_t;

    function automatic logic [7:0] pkt_byte(input bus_req_t req, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0: begin
                b[HDR_MARK_BIT]         = 1'b1;
                b[HDR_RW_BIT]           = req.rw;
                b[HDR_UDS_BIT]          = req.uds;
                b[HDR_LDS_BIT]          = req.lds;
                b[HDR_FC_LSB +: 3]      = req.fc;
            end
            3'd1:    b = req.addr_hi[22:15];
            3'd2:    b = req.addr_hi[14:7];
            3'd3:    b = {req.addr_hi[6:0], 1'b0};
            3'd4:    b = req.data[15:8];
            3'd5:    b = req.data[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_sequencer.sv
// Walks the request packet one byte at a time, issuing a byte only when the
// UART is idle and leaving at least one dead cycle between issue strobes.
module uart_tx_sequencer
    import m68k_bridge_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       en_i,
    input  bus_req_t   req_i,
    input  logic       tx_busy_i,
    output logic [7:0] tx_data_o,
    output logic       new_tx_data_o,
    output logic       done_o
);

    localparam logic [2:0] LAST_RD = 3'(PKT_LEN_RD - 1);
    localparam logic [2:0] LAST_WR = 3'(PKT_LEN_WR - 1);

    logic [2:0] idx_q, idx_d;
    logic       issued_q;
    logic       issue;
    logic       last;

    // The dead cycle covers the UART's one-cycle lag in raising tx_busy.
    assign issue         = en_i && !tx_busy_i && !issued_q;
    assign last          = (idx_q == (req_i.rw ? LAST_RD : LAST_WR));
    assign done_o        = issue && last;
    assign new_tx_data_o = issue;
    assign tx_data_o     = en_i ? pkt_byte(req_i, idx_q) : 8'h00;

    always_comb begin
        idx_d = idx_q;
        if (start_i) begin
            idx_d = 3'd0;
        end else if (issue) begin
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= 3'd0;
            issued_q <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            issued_q <= issue;
        end
    end

endmodule

// File: rtl/m68k_bus_sequencer.sv
// Turns each sampled 68000 bus cycle into a UART request packet, waits for the
// host's reply and terminates the cycle with DTACK (plus read data) or BERR.
module m68k_bus_sequencer
    import m68k_bridge_pkg::*;
#(
    parameter int         TIMEOUT_W = 24,
    parameter logic [7:0] ACK_BYTE  = ACK_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_reset_n,
    input  logic        as_i,
    input  logic        rw_i,
    input  logic        uds_i,
    input  logic        lds_i,
    input  logic [2:0]  fc_i,
    input  logic [23:0] addr_i,
    input  logic [15:0] data_i,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        new_rx_data,
    output logic        dtack,
    output logic        berr,
    output logic [15:0] d_out,
    output logic        busy
);

    localparam logic [TIMEOUT_W-1:0] CNT_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    // Saturation is reached on the cycle the counter would step to all-ones.
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = ~CNT_ONE;

    state_e                state_q, state_d;
    bus_req_t              req_q, req_d;
    logic                  as_q;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
    logic                  rcnt_q, rcnt_d;
    logic                  dtack_q, dtack_d;
    logic                  berr_q, berr_d;
    logic [15:0]           dout_q, dout_d;
    logic                  tx_start;
    logic                  tx_en;
    logic                  tx_done;
    logic                  timeout;
    logic                  unused_addr0;

    assign unused_addr0 = addr_i[0];
    assign timeout      = (cnt_q == CNT_LAST);
    assign tx_en        = (state_q == S_TX) && as_i && cpu_reset_n;

    uart_tx_sequencer u_tx (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (tx_start),
        .en_i          (tx_en),
        .req_i         (req_q),
        .tx_busy_i     (tx_busy),
        .tx_data_o     (tx_data),
        .new_tx_data_o (new_tx_data),
        .done_o        (tx_done)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        cnt_d    = cnt_q;
        rcnt_d   = rcnt_q;
        dtack_d  = dtack_q;
        berr_d   = berr_q;
        dout_d   = dout_q;
        tx_start = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (as_i && !as_q) begin
                    req_d.rw      = rw_i;
                    req_d.uds     = uds_i;
                    req_d.lds     = lds_i;
                    req_d.fc      = fc_i;
                    req_d.addr_hi = addr_i[23:1];
                    req_d.data    = data_i;
                    dout_d        = 16'h0000;
                    tx_start      = 1'b1;
                    state_d       = S_TX;
                end
            end

            S_TX: begin
                if (!as_i) begin
                    state_d = S_IDLE;
                    dout_d  = 16'h0000;
                end else if (tx_done) begin
                    state_d = S_RX_STAT;
                    cnt_d   = '0;
                end
            end

            S_RX_STAT: begin
                if (!as_i) begin
                    state_d = S_IDLE;
                    dout_d  = 16'h0000;
                end else if (new_rx_data) begin
                    cnt_d = '0;
                    if (rx_data != ACK_BYTE) begin
                        state_d = S_TERM;
                        berr_d  = 1'b1;
                    end else if (req_q.rw) begin
                        state_d = S_RX_DATA;
                        rcnt_d  = 1'b0;
                    end else begin
                        state_d = S_TERM;
                        dtack_d = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = S_TERM;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_RX_DATA: begin
                if (!as_i) begin
                    state_d = S_IDLE;
                    dout_d  = 16'h0000;
                end else if (new_rx_data) begin
                    cnt_d = '0;
                    if (!rcnt_q) begin
                        dout_d[15:8] = rx_data;
                        rcnt_d       = 1'b1;
                    end else begin
                        dout_d[7:0] = rx_data;
                        state_d     = S_TERM;
                        dtack_d     = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = S_TERM;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_TERM: begin
                if (!as_i) begin
                    state_d = S_IDLE;
                    dtack_d = 1'b0;
                    berr_d  = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // CPU reset overrides everything, including a same-cycle AS edge.
        if (!cpu_reset_n) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            rcnt_d   = 1'b0;
            dtack_d  = 1'b0;
            berr_d   = 1'b0;
            dout_d   = 16'h0000;
            tx_start = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            as_q    <= 1'b0;
            cnt_q   <= '0;
            rcnt_q  <= 1'b0;
            dtack_q <= 1'b0;
            berr_q  <= 1'b0;
            dout_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            as_q    <= as_i;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            dtack_q <= dtack_d;
            berr_q  <= berr_d;
            dout_q  <= dout_d;
        end
    end

    assign dtack = dtack_q;
    assign berr  = berr_q;
    assign d_out = dout_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_m68k_bus_sequencer.sv
// Bench for m68k_bus_sequencer: directed vector table, multi-cycle corner
// sequences and randomized transactions checked against a packet-level model.
module tb_m68k_bus_sequencer;

    localparam int TW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_reset_n;
    logic        as_i, rw_i, uds_i, lds_i;
    logic [2:0]  fc_i;
    logic [23:0] addr_i;
    logic [15:0] data_i;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        new_rx_data;
    logic        dtack, berr;
    logic [15:0] d_out;
    logic        busy;

    always #5 clk = ~clk;

    m68k_bus_sequencer #(.TIMEOUT_W(TW), .ACK_BYTE(8'h06)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_reset_n(cpu_reset_n),
        .as_i(as_i), .rw_i(rw_i), .uds_i(uds_i), .lds_i(lds_i),
        .fc_i(fc_i), .addr_i(addr_i), .data_i(data_i),
        .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
        .rx_data(rx_data), .new_rx_data(new_rx_data),
        .dtack(dtack), .berr(berr), .d_out(d_out), .busy(busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] b;
        int         cyc;
        logic       bsy;
    } strobe_t;

    strobe_t tx_q[$];
    always @(negedge clk) if (new_tx_data === 1'b1) tx_q.push_back('{tx_data, cyc, tx_busy});

    // tx / rx hold bytes first-in-MSB.
    typedef struct packed {
        logic        rw, uds, lds;
        logic [2:0]  fc;
        logic [23:0] addr;
        logic [15:0] data;
        logic [23:0] rx;
        int          n_rx;
        logic [47:0] tx;
        int          n_tx;
        logic        exp_dtack, exp_berr;
        logic [15:0] exp_dout;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    int start_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input logic rw, uds, lds, input logic [2:0] fc,
                                 input logic [23:0] addr, input logic [15:0] data,
                                 input logic [23:0] rx, input int n_rx,
                                 input logic [47:0] tx, input int n_tx,
                                 input logic ed, eb, input logic [15:0] dout);
        vec_t v;
        v.rw = rw; v.uds = uds; v.lds = lds; v.fc = fc; v.addr = addr; v.data = data;
        v.rx = rx; v.n_rx = n_rx; v.tx = tx; v.n_tx = n_tx;
        v.exp_dtack = ed; v.exp_berr = eb; v.exp_dout = dout;
        return v;
    endfunction

    // Packet-level reference: what the host should see and how the cycle ends.
    function automatic vec_t model(input logic rw, uds, lds, input logic [2:0] fc,
                                   input logic [23:0] addr, input logic [15:0] data,
                                   input logic [7:0] stat, input logic [15:0] rd);
        vec_t v;
        int hdr;
        hdr = 128 + 64 * rw + 32 * uds + 16 * lds + fc;
        v = mkv(rw, uds, lds, fc, addr, data, 24'h0, 0, 48'h0, 0, 1'b0, 1'b0, 16'h0);
        v.tx = {8'(hdr), 8'(addr / 65536), 8'(addr / 256), 8'(addr % 256) & 8'hFE,
                8'(data / 256), 8'(data % 256)};
        if (rw) v.tx[15:0] = 16'h0;
        v.n_tx = rw ? 4 : 6;
        if (stat != 8'h06) begin
            v.rx = {stat, 16'h0}; v.n_rx = 1; v.exp_berr = 1'b1;
        end else if (!rw) begin
            v.rx = {stat, 16'h0}; v.n_rx = 1; v.exp_dtack = 1'b1;
        end else begin
            v.rx = {stat, rd}; v.n_rx = 3; v.exp_dtack = 1'b1; v.exp_dout = rd;
        end
        return v;
    endfunction

    task automatic start_cycle(input vec_t v);
        tx_q.delete();
        rw_i = v.rw; uds_i = v.uds; lds_i = v.lds; fc_i = v.fc;
        addr_i = v.addr; data_i = v.data; as_i = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic wait_tx(input int n, input bit rnd);
        int b = 0;
        while (tx_q.size() < n && b < 600) begin
            @(posedge clk);
            #1;
            if (rnd) tx_busy = ($urandom_range(0, 2) == 0);
            b++;
        end
        tx_busy = 1'b0;
        if (tx_q.size() < n) chk("tx_count_timeout", tx_q.size(), n);
    endtask

    task automatic check_tx(input vec_t v);
        for (int i = 0; i < v.n_tx && i < tx_q.size(); i++) begin
            chk($sformatf("tx_byte%0d", i), tx_q[i].b, v.tx[47 - 8 * i -: 8]);
            chk("tx_while_busy", tx_q[i].bsy, 0);
            if (i > 0) chk("tx_gap", (tx_q[i].cyc - tx_q[i-1].cyc) >= 2, 1);
        end
    endtask

    task automatic drop_as(input logic ed, input logic eb);
        @(posedge clk);
        #1;
        as_i = 1'b0;
        @(negedge clk);
        chk("term_hold_dtack", dtack, ed);
        chk("term_hold_berr", berr, eb);
        @(negedge clk);
        chk("deassert_dtack", dtack, 0);
        chk("deassert_berr", berr, 0);
        chk("deassert_busy", busy, 0);
    endtask

    task automatic reply_finish(input vec_t v);
        repeat ($urandom_range(0, 3)) tick();
        for (int i = 0; i < v.n_rx; i++) begin
            rx_data = v.rx[23 - 8 * i -: 8];
            new_rx_data = 1'b1;
            tick();
            new_rx_data = 1'b0;
            if (i < v.n_rx - 1) repeat ($urandom_range(0, 3)) tick();
        end
        @(negedge clk);
        chk("term_dtack", dtack, v.exp_dtack);
        chk("term_berr", berr, v.exp_berr);
        if (v.exp_dtack && v.rw) chk("read_data", d_out, v.exp_dout);
        chk("tx_total", tx_q.size(), v.n_tx);
        repeat (3) @(negedge clk);
        chk("hold_dtack", dtack, v.exp_dtack);
        chk("hold_berr", berr, v.exp_berr);
        if (v.exp_dtack && v.rw) chk("hold_data", d_out, v.exp_dout);
        drop_as(v.exp_dtack, v.exp_berr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, got no finish, expected finish");
        $fatal(1);
    end

    vec_t tbl[5];
    vec_t v;

    initial begin
        int last;
        int bc;
        rst_n = 1'b0; cpu_reset_n = 1'b1; as_i = 1'b0; rw_i = 1'b0; uds_i = 1'b0; lds_i = 1'b0;
        fc_i = 3'd0; addr_i = 24'h0; data_i = 16'h0; tx_busy = 1'b0; rx_data = 8'h0; new_rx_data = 1'b0;

        // rw uds lds fc addr data | rx bytes, n | expected tx bytes, n | dtack berr d_out
        tbl[0] = mkv(0, 1, 1, 3'd5, 24'h012344, 16'hBEEF, 24'h060000, 1,
                     48'hB5_01_23_44_BE_EF, 6, 1, 0, 16'h0000);
        tbl[1] = mkv(1, 0, 1, 3'd6, 24'hFF0001, 16'h0000, 24'h06_12_34, 3,
                     48'hD6_FF_00_00_00_00, 4, 1, 0, 16'h1234);
        tbl[2] = mkv(0, 1, 0, 3'd3, 24'h00ABCD, 16'h5A5A, 24'h150000, 1,
                     48'hA3_00_AB_CC_5A_5A, 6, 0, 1, 16'h0000);
        tbl[3] = mkv(1, 1, 0, 3'd2, 24'h800100, 16'h0000, 24'h06_FF_00, 3,
                     48'hE2_80_01_00_00_00, 4, 1, 0, 16'hFF00);
        tbl[4] = mkv(1, 1, 1, 3'd1, 24'h000002, 16'h0000, 24'h000000, 1,
                     48'hF1_00_00_02_00_00, 4, 0, 1, 16'h0000);

        #12;
        chk("rst_dtack", dtack, 0);
        chk("rst_berr", berr, 0);
        chk("rst_dout", d_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_new_tx", new_tx_data, 0);
        chk("rst_tx_data", tx_data, 0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            start_cycle(tbl[i]);
            wait_tx(tbl[i].n_tx, 1'b0);
            if (tx_q.size() > 0) chk("first_strobe_latency", tx_q[0].cyc - start_cyc, 1);
            check_tx(tbl[i]);
            reply_finish(tbl[i]);
            tick();
        end

        // Backpressure: UART busy for 100 cycles after the second byte.
        start_cycle(tbl[0]);
        wait_tx(2, 1'b0);
        tx_busy = 1'b1;
        repeat (100) tick();
        chk("bp_no_strobe", tx_q.size(), 2);
        tx_busy = 1'b0;
        wait_tx(6, 1'b0);
        check_tx(tbl[0]);
        reply_finish(tbl[0]);
        tick();

        // Timeout: 2^TW-1 counting cycles, so BERR is registered on the 15th
        // edge after the edge that took the last byte, i.e. seen 16 samples later.
        start_cycle(tbl[1]);
        wait_tx(4, 1'b0);
        check_tx(tbl[1]);
        last = (tx_q.size() >= 4) ? tx_q[3].cyc : 0;
        bc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (berr === 1'b1) begin
                bc = cyc;
                break;
            end
        end
        chk("timeout_latency", bc - last, 16);
        chk("timeout_no_dtack", dtack, 0);
        drop_as(1'b0, 1'b1);
        tick();

        // Reply byte in the same cycle the timeout would fire: the byte wins.
        start_cycle(tbl[0]);
        wait_tx(6, 1'b0);
        check_tx(tbl[0]);
        last = (tx_q.size() >= 6) ? tx_q[5].cyc : cyc;
        while (cyc < last + 15) begin
            @(posedge clk);
            #1;
        end
        rx_data = 8'h06; new_rx_data = 1'b1;
        tick();
        new_rx_data = 1'b0;
        @(negedge clk);
        chk("race_byte_dtack", dtack, 1);
        chk("race_byte_berr", berr, 0);
        drop_as(1'b1, 1'b0);
        tick();

        // AS falls in the same cycle as the final reply byte: no termination.
        start_cycle(tbl[0]);
        wait_tx(6, 1'b0);
        tick();
        as_i = 1'b0; rx_data = 8'h06; new_rx_data = 1'b1;
        tick();
        new_rx_data = 1'b0;
        @(negedge clk);
        chk("as_race_dtack", dtack, 0);
        chk("as_race_berr", berr, 0);
        chk("as_race_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("as_race_stays_idle", {dtack, berr, busy}, 3'b000);
        tick();

        // CPU reset while collecting read data.
        start_cycle(tbl[1]);
        wait_tx(4, 1'b0);
        rx_data = 8'h06; new_rx_data = 1'b1; tick();
        rx_data = 8'h12; tick();
        new_rx_data = 1'b0;
        cpu_reset_n = 1'b0;
        tick();
        cpu_reset_n = 1'b1;
        @(negedge clk);
        chk("cpurst_busy", busy, 0);
        chk("cpurst_dtack", dtack, 0);
        chk("cpurst_dout", d_out, 0);
        tick();
        rx_data = 8'h34; new_rx_data = 1'b1; tick();
        new_rx_data = 1'b0;
        @(negedge clk);
        chk("cpurst_stray_rx", {dtack, berr, busy}, 3'b000);
        tick();
        as_i = 1'b0;
        tick();

        // Async reset in the middle of a byte strobe.
        start_cycle(tbl[0]);
        wait_tx(2, 1'b0);
        tick();
        #1;
        chk("pre_rst_strobe", new_tx_data, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_new_tx", new_tx_data, 0);
        chk("async_rst_tx_data", tx_data, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_term", {dtack, berr, d_out}, 18'h0);
        tick();
        rst_n = 1'b1;
        as_i = 1'b0;
        tick();
        tick();

        // Randomized transactions against the packet-level model.
        for (int t = 0; t < 30; t++) begin
            logic [1:0] ds;
            logic [7:0] stat;
            ds = 2'($urandom_range(1, 3));
            stat = 8'h06;
            if ($urandom_range(0, 3) == 0) begin
                do stat = 8'($urandom_range(0, 255)); while (stat == 8'h06);
            end
            v = model(1'($urandom_range(0, 1)), ds[1], ds[0], 3'($urandom_range(0, 7)),
                      24'($urandom), 16'($urandom), stat, 16'($urandom));
            start_cycle(v);
            wait_tx(v.n_tx, 1'b1);
            check_tx(v);
            reply_finish(v);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
